// File: rtl/inst_issue_unit_pkg.sv
// Shared issue-stage constants: FU ranges, opcode map, FU class encoding and decode helpers.
package inst_issue_unit_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int FU_NUM       = 8;
  localparam int FU_INDEX     = 4;
  localparam int RB_INDEX     = 4;
  localparam int IQ_DEPTH     = 4;

  localparam int BR_LO  = 0;
  localparam int BR_HI  = 1;
  localparam int ALU_LO = 2;
  localparam int ALU_HI = 5;
  localparam int MEM_LO = 6;
  localparam int MEM_HI = 7;

  localparam logic [FU_INDEX-1:0] NULL_FU = '1;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t INST_ADD  = 6'h00;
  localparam opcode_t INST_BEQ  = 6'h04;
  localparam opcode_t INST_BNE  = 6'h05;
  localparam opcode_t INST_BGE  = 6'h06;
  localparam opcode_t INST_ADDI = 6'h08;
  localparam opcode_t INST_ANDI = 6'h0C;
  localparam opcode_t INST_LW   = 6'h23;
  localparam opcode_t INST_SW   = 6'h2B;

  typedef enum logic [1:0] {CL_ALU, CL_MEM, CL_BR, CL_BAD} fu_class_t;

  function automatic fu_class_t op_to_class(input opcode_t op);
    fu_class_t c;
    case (op)
      INST_BEQ, INST_BNE, INST_BGE:   c = CL_BR;
      INST_ADD, INST_ADDI, INST_ANDI: c = CL_ALU;
      INST_LW, INST_SW:               c = CL_MEM;
      default:                        c = CL_BAD;
    endcase
    return c;
  endfunction

  // One bit per RS that can execute the class; CL_BAD yields an empty mask.
  function automatic logic [FU_NUM-1:0] class_mask(input fu_class_t c);
    logic [FU_NUM-1:0] m;
    int lo;
    int hi;
    case (c)
      CL_BR:   begin lo = BR_LO;  hi = BR_HI;  end
      CL_ALU:  begin lo = ALU_LO; hi = ALU_HI; end
      CL_MEM:  begin lo = MEM_LO; hi = MEM_HI; end
      default: begin lo = 1;      hi = 0;      end
    endcase
    for (int i = 0; i < FU_NUM; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

endpackage

// File: rtl/inst_issue_unit_queue.sv
// In-order instruction queue: push/pop/flush, head visible combinationally, pointers wrap modulo DEPTH.
module inst_issue_unit_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses the push even when the head leaves in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_issue_unit.sv
// Tomasulo issue stage: in-order queue, head decode, lowest free RS pick, one registered issue per cycle.
// Optional ISSUE_STATS_EN adds saturating issue/stall counters.
module inst_issue_unit
  import inst_issue_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_valid,
  input  logic [WORD_SIZE-1:0] fetch_inst,
  output logic                 fetch_ready,
  input  logic [FU_NUM-1:0]    busy_in,
  input  logic                 rb_alloc_ready,
  input  logic [RB_INDEX-1:0]  rb_alloc_index,
  output logic                 rb_alloc_take,
  output logic [FU_INDEX-1:0]  fu,
  output logic [RB_INDEX-1:0]  RB_index,
  output logic [WORD_SIZE-1:0] inst,
  input  logic                 flush,
  output logic                 illegal_op
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
`endif
);

  logic [WORD_SIZE-1:0] head;
  logic                 full;
  logic                 empty;
  fu_class_t            head_class;
  logic [FU_NUM-1:0]    last_mask;
  logic [FU_NUM-1:0]    free;
  logic [FU_INDEX-1:0]  sel;
  logic                 issue;
  logic                 drop;

  inst_issue_unit_queue #(.DEPTH(IQ_DEPTH), .WIDTH(WORD_SIZE)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fetch_valid),
    .push_data (fetch_inst),
    .pop       (issue || drop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign fetch_ready = !full;

  always_comb begin
    head_class = op_to_class(head[WORD_SIZE-1 -: OPCODE_WIDTH]);
    // The RS picked last cycle still reads as free on busy_in; mask it.
    for (int i = 0; i < FU_NUM; i++) last_mask[i] = (fu == FU_INDEX'(i));
    free = ~busy_in & ~last_mask & class_mask(head_class);
    sel  = NULL_FU;
    for (int i = FU_NUM-1; i >= 0; i--) begin
      if (free[i]) sel = FU_INDEX'(i);
    end
    issue = !empty && !flush && rb_alloc_ready && (head_class != CL_BAD) && (|free);
    drop  = !empty && !flush && (head_class == CL_BAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fu            <= NULL_FU;
      RB_index      <= '0;
      inst          <= '0;
      rb_alloc_take <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      fu            <= issue ? sel : NULL_FU;
      rb_alloc_take <= issue;
      illegal_op    <= drop;
      if (issue) begin
        RB_index <= rb_alloc_index;
        inst     <= head;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
      if (!empty && !flush && !issue && !drop && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_issue_unit.sv
// Directed bench for inst_issue_unit: single-issue vector table plus multi-cycle corner sequences.
module tb_inst_issue_unit;
  import inst_issue_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 fetch_valid;
  logic [WORD_SIZE-1:0] fetch_inst;
  logic                 fetch_ready;
  logic [FU_NUM-1:0]    busy_in;
  logic                 rb_alloc_ready;
  logic [RB_INDEX-1:0]  rb_alloc_index;
  logic                 rb_alloc_take;
  logic [FU_INDEX-1:0]  fu;
  logic [RB_INDEX-1:0]  RB_index;
  logic [WORD_SIZE-1:0] inst;
  logic                 flush;
  logic                 illegal_op;
`ifdef ISSUE_STATS_EN
  logic [31:0]          stat_issued;
  logic [31:0]          stat_stall;
`endif

  always #5 clk = ~clk;

  inst_issue_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .fetch_ready    (fetch_ready),
    .busy_in        (busy_in),
    .rb_alloc_ready (rb_alloc_ready),
    .rb_alloc_index (rb_alloc_index),
    .rb_alloc_take  (rb_alloc_take),
    .fu             (fu),
    .RB_index       (RB_index),
    .inst           (inst),
    .flush          (flush),
    .illegal_op     (illegal_op)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_stall     (stat_stall)
`endif
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] pl);
    return {op, pl};
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [7:0]  busy;
    logic [3:0]  rb;
    logic [3:0]  exp_fu;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[9];
  logic [3:0]  last_rb;
  logic [31:0] last_inst;
  logic [31:0] w0, w1, w2, w3, w4;

  initial begin
    vecs[0] = '{mk(INST_BGE,  26'h0000111), 8'b0000_0000, 4'd3,  4'd0, 1'b0};
    vecs[1] = '{mk(INST_BGE,  26'h0000222), 8'b0000_0001, 4'd5,  4'd1, 1'b0};
    vecs[2] = '{mk(INST_ADD,  26'h0000333), 8'b0000_0000, 4'd6,  4'd2, 1'b0};
    vecs[3] = '{mk(INST_ADDI, 26'h0000444), 8'b0000_1100, 4'd7,  4'd4, 1'b0};
    vecs[4] = '{mk(INST_LW,   26'h0000555), 8'b0000_0000, 4'd8,  4'd6, 1'b0};
    vecs[5] = '{mk(INST_SW,   26'h0000666), 8'b0100_0000, 4'd9,  4'd7, 1'b0};
    vecs[6] = '{mk(INST_ANDI, 26'h0000777), 8'b0001_1100, 4'd10, 4'd5, 1'b0};
    vecs[7] = '{mk(INST_BEQ,  26'h0000888), 8'b1111_1100, 4'd11, 4'd0, 1'b0};
    vecs[8] = '{mk(6'h3F,     26'h0000999), 8'b0000_0000, 4'd12, 4'hF, 1'b1};

    reset_n = 1'b0; fetch_valid = 1'b0; fetch_inst = '0; busy_in = '0;
    rb_alloc_ready = 1'b1; rb_alloc_index = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_fu", 32'(fu), 32'hF);
    check("reset_rb_index", 32'(RB_index), 0);
    check("reset_inst", inst, 0);
    check("reset_take", 32'(rb_alloc_take), 0);
    check("reset_illegal", 32'(illegal_op), 0);
    check("reset_fetch_ready", 32'(fetch_ready), 1);
    reset_n = 1'b1;
    last_rb = 4'd0; last_inst = 32'd0;

    // Single-instruction vectors: push, check latency, issue, then idle.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      fetch_valid = 1'b1; fetch_inst = vecs[k].word;
      busy_in = vecs[k].busy; rb_alloc_index = vecs[k].rb;
      @(negedge clk);
      fetch_valid = 1'b0;
      check($sformatf("v%0d_latency_fu", k), 32'(fu), 32'hF);
      @(negedge clk);
      if (!vecs[k].exp_ill) begin
        last_rb = vecs[k].rb; last_inst = vecs[k].word;
      end
      check($sformatf("v%0d_fu", k), 32'(fu), 32'(vecs[k].exp_fu));
      check($sformatf("v%0d_illegal", k), 32'(illegal_op), 32'(vecs[k].exp_ill));
      check($sformatf("v%0d_take", k), 32'(rb_alloc_take), 32'(!vecs[k].exp_ill));
      check($sformatf("v%0d_rb_index", k), 32'(RB_index), 32'(last_rb));
      check($sformatf("v%0d_inst", k), inst, last_inst);
      @(negedge clk);
      check($sformatf("v%0d_after_fu", k), 32'(fu), 32'hF);
      check($sformatf("v%0d_after_take", k), 32'(rb_alloc_take), 0);
      check($sformatf("v%0d_after_illegal", k), 32'(illegal_op), 0);
    end

    // Back-to-back branches: the late busy rise must not double-book RS 0.
    busy_in = '0;
    w0 = mk(INST_BGE, 26'h00000B1); w1 = mk(INST_BGE, 26'h00000B2);
    @(negedge clk); fetch_valid = 1'b1; fetch_inst = w0;
    @(negedge clk); fetch_inst = w1; rb_alloc_index = 4'd1;
    @(negedge clk); fetch_valid = 1'b0; rb_alloc_index = 4'd2;
    check("b2b_first_fu", 32'(fu), 0);
    check("b2b_first_inst", inst, w0);
    check("b2b_first_rb", 32'(RB_index), 1);
    @(negedge clk);
    check("b2b_second_fu", 32'(fu), 1);
    check("b2b_second_inst", inst, w1);
    check("b2b_second_rb", 32'(RB_index), 2);
    @(negedge clk);
    check("b2b_idle_fu", 32'(fu), 32'hF);

    // ALU head blocked by busy ALU RSs; the branch behind it must wait.
    busy_in = 8'b0011_1100; rb_alloc_index = 4'd7;
    w0 = mk(INST_ADD, 26'h00000C1); w1 = mk(INST_BGE, 26'h00000C2);
    @(negedge clk); fetch_valid = 1'b1; fetch_inst = w0;
    @(negedge clk); fetch_inst = w1;
    @(negedge clk); fetch_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stall_fu_%0d", j), 32'(fu), 32'hF);
      check($sformatf("stall_take_%0d", j), 32'(rb_alloc_take), 0);
      @(negedge clk);
    end
    busy_in = '0;
    @(negedge clk);
    check("stall_release_fu0", 32'(fu), 2);
    check("stall_release_inst0", inst, w0);
    @(negedge clk);
    check("stall_release_fu1", 32'(fu), 0);
    check("stall_release_inst1", inst, w1);
    @(negedge clk);
    check("stall_release_idle", 32'(fu), 32'hF);

    // Fill the queue with the RB unavailable; a fifth fetch is refused.
    rb_alloc_ready = 1'b0; busy_in = '0; rb_alloc_index = 4'd9;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); fetch_valid = 1'b1; fetch_inst = mk(INST_BGE, 26'(32'hD0 + j));
    end
    @(negedge clk);
    check("fill_full_ready", 32'(fetch_ready), 0);
    fetch_inst = mk(INST_BGE, 26'h00000DF);
    @(negedge clk);
    fetch_valid = 1'b0;
    check("fill_still_full", 32'(fetch_ready), 0);
    check("fill_no_issue", 32'(fu), 32'hF);
    rb_alloc_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("fill_drain_fu_%0d", j), 32'(fu), 32'(j % 2));
      check($sformatf("fill_drain_inst_%0d", j), inst, mk(INST_BGE, 26'(32'hD0 + j)));
      check($sformatf("fill_drain_take_%0d", j), 32'(rb_alloc_take), 1);
    end
    @(negedge clk);
    check("fill_fifth_dropped", 32'(fu), 32'hF);
    check("fill_ready_again", 32'(fetch_ready), 1);

    // Illegal opcode at head is dropped, the next entry issues one cycle later.
    w0 = mk(6'h3F, 26'h00000E1); w1 = mk(INST_ADD, 26'h00000E2);
    @(negedge clk); fetch_valid = 1'b1; fetch_inst = w0;
    @(negedge clk); fetch_inst = w1;
    @(negedge clk); fetch_valid = 1'b0;
    check("illegal_pulse", 32'(illegal_op), 1);
    check("illegal_fu", 32'(fu), 32'hF);
    check("illegal_take", 32'(rb_alloc_take), 0);
    @(negedge clk);
    check("illegal_pulse_end", 32'(illegal_op), 0);
    check("illegal_next_fu", 32'(fu), 2);
    check("illegal_next_inst", inst, w1);
    @(negedge clk);

    // Flush with three entries queued and a same-cycle fetch.
    rb_alloc_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); fetch_valid = 1'b1; fetch_inst = mk(INST_ADD, 26'(32'hF0 + j));
    end
    @(negedge clk);
    flush = 1'b1; fetch_inst = mk(INST_BGE, 26'h00000F7); rb_alloc_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b0;
    check("flush_fu", 32'(fu), 32'hF);
    check("flush_take", 32'(rb_alloc_take), 0);
    check("flush_ready", 32'(fetch_ready), 1);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check($sformatf("flush_empty_fu_%0d", j), 32'(fu), 32'hF);
      check($sformatf("flush_empty_take_%0d", j), 32'(rb_alloc_take), 0);
    end

    // Asynchronous reset while an issue is on the outputs.
    w0 = mk(INST_BGE, 26'h0000A01); rb_alloc_index = 4'd4;
    @(negedge clk); fetch_valid = 1'b1; fetch_inst = w0;
    @(negedge clk); fetch_valid = 1'b0;
    @(negedge clk);
    check("areset_pre_fu", 32'(fu), 0);
    #1 reset_n = 1'b0;
    #1;
    check("areset_fu", 32'(fu), 32'hF);
    check("areset_rb_index", 32'(RB_index), 0);
    check("areset_inst", inst, 0);
    check("areset_take", 32'(rb_alloc_take), 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("areset_after_fu", 32'(fu), 32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
